// File: rtl/exe_mem_status_stage_pkg.sv
// Shared encodings for the EX->MEM stage: ALU commands, condition codes,
// NZCV bit positions and the registered control bundle.
package exe_mem_status_stage_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001,
    COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101,
    COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001,
    COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101,
    COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } mem_ctrl_t;

  // Only the add/subtract family produces a meaningful carry and overflow.
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_ADC) ||
           (cmd == CMD_SUB) || (cmd == CMD_SBC);
  endfunction

endpackage

// File: rtl/exe_mem_status_stage_cond_check.sv
// Combinational ARM condition-field evaluator against an NZCV flag set.
module cond_check
  import exe_mem_status_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Full decode of the 16 condition codes; 1111 is reserved and never passes.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_mem_status_stage.sv
// EX->MEM pipeline register with the NZCV status register. The ID-stage
// condition check sees the flags the EX instruction is about to write.
module exe_mem_status_stage
  import exe_mem_status_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic                  ex_mem_w_en,
  input  logic                  ex_s_bit,
  input  logic [3:0]            ex_cmd,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic                  ex_alu_carry,
  input  logic                  ex_alu_overflow,
  input  logic [DATA_W-1:0]     ex_val_rm,
  input  logic [3:0]            id_cond,
  output logic                  mem_valid,
  output logic                  mem_wb_en,
  output logic                  mem_mem_r_en,
  output logic                  mem_mem_w_en,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     mem_val_rm,
  output logic [3:0]            status,
  output logic                  alu_carry_in,
  output logic                  id_cond_pass
);

  mem_ctrl_t             ctrl_q, ctrl_d;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     res_q, rm_q;
  logic [3:0]            status_next;
  logic                  load;

  assign load = ~flush & ~freeze;

  // Control bits only survive when EX holds a real instruction.
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.valid    = ex_valid;
    ctrl_d.wb_en    = ex_wb_en    & ex_valid;
    ctrl_d.mem_r_en = ex_mem_r_en & ex_valid;
    ctrl_d.mem_w_en = ex_mem_w_en & ex_valid;
  end

  // Flags at the coming edge: reset clears, flush/freeze hold, S-bit loads.
  always_comb begin
    status_next = status;
    if (rst) begin
      status_next = '0;
    end else if (load && ex_valid && ex_s_bit) begin
      status_next[FLAG_N] = ex_alu_result[DATA_W-1];
      status_next[FLAG_Z] = (ex_alu_result == '0);
      if (is_arith(ex_cmd)) begin
        status_next[FLAG_C] = ex_alu_carry;
        status_next[FLAG_V] = ex_alu_overflow;
      end
    end
  end

  // Pipeline register: rst > flush (bubble) > freeze (hold) > load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ctrl_q <= '0;
      dest_q <= '0;
      res_q  <= '0;
      rm_q   <= '0;
    end else if (!freeze) begin
      ctrl_q <= ctrl_d;
      dest_q <= ex_dest;
      res_q  <= ex_alu_result;
      rm_q   <= ex_val_rm;
    end
  end

  // Status register follows the precomputed next value every edge.
  always_ff @(posedge clk) begin
    status <= status_next;
  end

  assign mem_valid      = ctrl_q.valid;
  assign mem_wb_en      = ctrl_q.wb_en;
  assign mem_mem_r_en   = ctrl_q.mem_r_en;
  assign mem_mem_w_en   = ctrl_q.mem_w_en;
  assign mem_dest       = dest_q;
  assign mem_alu_result = res_q;
  assign mem_val_rm     = rm_q;
  assign alu_carry_in   = status[FLAG_C];

  cond_check u_cond (
    .cond (id_cond),
    .nzcv (status_next),
    .pass (id_cond_pass)
  );

endmodule

// File: tb/tb_exe_mem_status_stage.sv
// Directed bench for exe_mem_status_stage: a flag/pipeline model checked
// every cycle, plus literal expectations for the planned scenarios.
module tb_exe_mem_status_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_s_bit;
  logic [3:0]  ex_cmd, ex_dest, id_cond;
  logic [31:0] ex_alu_result, ex_val_rm;
  logic        ex_alu_carry, ex_alu_overflow;
  logic        mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en;
  logic [3:0]  mem_dest, status;
  logic [31:0] mem_alu_result, mem_val_rm;
  logic        alu_carry_in, id_cond_pass;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  logic        m_valid, m_wb, m_rd, m_wr;
  logic [3:0]  m_dest, m_nzcv;
  logic [31:0] m_res, m_rm;

  exe_mem_status_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en), .ex_s_bit(ex_s_bit), .ex_cmd(ex_cmd),
    .ex_dest(ex_dest), .ex_alu_result(ex_alu_result), .ex_alu_carry(ex_alu_carry),
    .ex_alu_overflow(ex_alu_overflow), .ex_val_rm(ex_val_rm), .id_cond(id_cond),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_mem_r_en(mem_mem_r_en),
    .mem_mem_w_en(mem_mem_w_en), .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
    .mem_val_rm(mem_val_rm), .status(status), .alu_carry_in(alu_carry_in),
    .id_cond_pass(id_cond_pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags the coming edge will leave behind, from the current inputs.
  function automatic logic [3:0] model_next();
    logic [3:0] f;
    f = m_nzcv;
    if (rst) f = 4'b0000;
    else if (!flush && !freeze && ex_valid && ex_s_bit) begin
      f[3] = ex_alu_result[31];
      f[2] = (ex_alu_result == 32'd0);
      if (ex_cmd >= 4'd2 && ex_cmd <= 4'd5) f[1:0] = {ex_alu_carry, ex_alu_overflow};
    end
    return f;
  endfunction

  // Pairs of conditions share a test; the odd code is its negation.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // Model update at each active edge.
  always @(posedge clk) begin
    logic [3:0] nf;
    nf = model_next();
    if (rst || flush) begin
      {m_valid, m_wb, m_rd, m_wr} = 4'b0;
      m_dest = 4'd0; m_res = 32'd0; m_rm = 32'd0;
    end else if (!freeze) begin
      m_valid = ex_valid;
      m_wb = ex_wb_en && ex_valid;
      m_rd = ex_mem_r_en && ex_valid;
      m_wr = ex_mem_w_en && ex_valid;
      m_dest = ex_dest; m_res = ex_alu_result; m_rm = ex_val_rm;
    end
    m_nzcv = nf;
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_valid", 32'(mem_valid), 32'(m_valid));
      chk("mem_wb_en", 32'(mem_wb_en), 32'(m_wb));
      chk("mem_mem_r_en", 32'(mem_mem_r_en), 32'(m_rd));
      chk("mem_mem_w_en", 32'(mem_mem_w_en), 32'(m_wr));
      chk("mem_dest", 32'(mem_dest), 32'(m_dest));
      chk("mem_alu_result", mem_alu_result, m_res);
      chk("mem_val_rm", mem_val_rm, m_rm);
      chk("status", 32'(status), 32'(m_nzcv));
      chk("alu_carry_in", 32'(alu_carry_in), 32'(m_nzcv[1]));
      chk("id_cond_pass", 32'(id_cond_pass), 32'(model_cond(id_cond, model_next())));
    end
  end

  task automatic drive(input logic v, input logic s, input logic [3:0] cmd,
                       input logic [31:0] res, input logic cy, input logic ov,
                       input logic [3:0] cond);
    ex_valid = v; ex_wb_en = 1'b1; ex_mem_r_en = 1'b0; ex_mem_w_en = 1'b1;
    ex_s_bit = s; ex_cmd = cmd; ex_alu_result = res;
    ex_alu_carry = cy; ex_alu_overflow = ov; id_cond = cond;
    ex_dest = res[3:0] ^ 4'h5; ex_val_rm = ~res;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'b0000);
    next(); next();
    chk_en = 1'b1;

    // reset state
    rst = 1'b0;
    @(negedge clk);
    chk("rst status", 32'(status), 32'h0);
    chk("rst mem_valid", 32'(mem_valid), 32'h0);
    chk("rst mem_alu_result", mem_alu_result, 32'h0);
    chk("rst EQ pass", 32'(id_cond_pass), 32'h0);
    id_cond = 4'b1110; #1;
    chk("rst AL pass", 32'(id_cond_pass), 32'h1);

    // ADDS result 0, carry 1
    next();
    drive(1'b1, 1'b1, 4'b0010, 32'h0, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    chk("adds EQ bypass", 32'(id_cond_pass), 32'h1);
    next();
    chk("adds status", 32'(status), 32'h6);
    chk("adds result", mem_alu_result, 32'h0);
    chk("adds carry_in", 32'(alu_carry_in), 32'h1);
    chk("adds dest", 32'(mem_dest), 32'h5);

    // SUBS to reach 0011, then ANDS 0x80000000
    drive(1'b1, 1'b1, 4'b0100, 32'h12, 1'b1, 1'b1, 4'b0000);
    next();
    chk("subs status", 32'(status), 32'h3);
    drive(1'b1, 1'b1, 4'b0110, 32'h8000_0000, 1'b0, 1'b0, 4'b1010);
    @(negedge clk);
    chk("ands GE bypass", 32'(id_cond_pass), 32'h1);
    next();
    chk("ands status", 32'(status), 32'hB);

    // freeze for 3 cycles with changing EX inputs
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'b0010, 32'h0 + 32'(i), 1'b0, 1'b0, 4'b1100);
      @(negedge clk);
      chk("frz GT pass", 32'(id_cond_pass), 32'h1);
      next();
      chk("frz status", 32'(status), 32'hB);
      chk("frz result", mem_alu_result, 32'h8000_0000);
    end

    // flush a SUBS with result 0
    freeze = 1'b0; flush = 1'b1;
    drive(1'b1, 1'b1, 4'b0100, 32'h0, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    chk("flush EQ pass", 32'(id_cond_pass), 32'h0);
    next();
    chk("flush mem_valid", 32'(mem_valid), 32'h0);
    chk("flush mem_wb_en", 32'(mem_wb_en), 32'h0);
    chk("flush status", 32'(status), 32'hB);

    // flush beats freeze
    flush = 1'b0;
    drive(1'b1, 1'b0, 4'b0001, 32'h77, 1'b0, 1'b0, 4'b1110);
    next();
    chk("load mem_valid", 32'(mem_valid), 32'h1);
    flush = 1'b1; freeze = 1'b1;
    next();
    chk("flush+frz valid", 32'(mem_valid), 32'h0);
    chk("flush+frz result", mem_alu_result, 32'h0);

    // reserved condition, invalid S instruction
    flush = 1'b0; freeze = 1'b0;
    drive(1'b0, 1'b1, 4'b0010, 32'h0, 1'b0, 1'b0, 4'b1111);
    @(negedge clk);
    chk("NV pass", 32'(id_cond_pass), 32'h0);
    next();
    chk("inval status", 32'(status), 32'hB);
    chk("inval wb_en", 32'(mem_wb_en), 32'h0);

    // directed mix exercising the model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] r;
      r = (i % 4 == 0) ? 32'h0 : {i[0], 27'h0, i[3:0]} ^ 32'h0F0F_0000;
      freeze = (i % 7 == 3); flush = (i % 9 == 5);
      drive(i % 5 != 2, 1'b1, 4'(i % 10), r, i[1], i[2], 4'(i));
      next();
    end

    // reset mid-operation
    freeze = 1'b0; flush = 1'b0; rst = 1'b1;
    drive(1'b1, 1'b1, 4'b0010, 32'h8000_0000, 1'b1, 1'b1, 4'b0100);
    @(negedge clk);
    chk("rst MI bypass", 32'(id_cond_pass), 32'h0);
    next();
    chk("rst2 status", 32'(status), 32'h0);
    chk("rst2 mem_valid", 32'(mem_valid), 32'h0);
    rst = 1'b0;
    next();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
